// File: rtl/fetch_unit_pkg.sv
// Shared core definitions for the fetch stage.
// State encoding, word width and reset/bubble constants.
package fetch_unit_pkg;

  localparam int XLEN = 32;

  localparam logic [XLEN-1:0] DEFAULT_RESET_PC = 32'h0000_0000;
  localparam logic [XLEN-1:0] DEFAULT_NOP_INSN = 32'h0000_0013;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    PRIME  = 2'd1,
    STREAM = 2'd2
  } fetch_state_t;

  function automatic logic [XLEN-1:0] pc_inc(
    input logic [XLEN-1:0] a
  );
    return a + 32'd4;
  endfunction

endpackage

// File: rtl/fetch_unit.sv
// Instruction fetch: PC, 1-cycle imem, skid buffer.
// Redirects squash in-flight words and cost two bubbles.
module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC = DEFAULT_RESET_PC,
  parameter logic [XLEN-1:0] NOP_INSN = DEFAULT_NOP_INSN
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            run,
  input  logic            stall,
  input  logic            redirect_en,
  input  logic [XLEN-1:0] redirect_pc,
  output logic [XLEN-1:0] imem_addr,
  input  logic [XLEN-1:0] imem_rdata,
  output logic [XLEN-1:0] insn,
  output logic [XLEN-1:0] pc,
  output logic            run_out
);

  fetch_state_t state, state_n;

  logic [XLEN-1:0] fetch_pc;
  logic [XLEN-1:0] rsp_pc;
  logic            rsp_valid;
  logic [XLEN-1:0] hold_insn;
  logic            hold_valid;

  logic [XLEN-1:0] target;
  logic [XLEN-1:0] rewind_pc;
  logic [XLEN-1:0] src;

  assign imem_addr = fetch_pc;
  assign target    = redirect_pc & ~32'h3;
  assign src       = hold_valid ? hold_insn : imem_rdata;

  // Unconsumed output is refetched first, else the in-flight word.
  assign rewind_pc = (run_out && stall) ? pc
                   : rsp_valid          ? rsp_pc
                   :                      fetch_pc;

  always_comb begin
    state_n = state;
    if (redirect_en) begin
      state_n = run ? PRIME : IDLE;
    end else if (!run) begin
      state_n = IDLE;
    end else begin
      unique case (state)
        IDLE, PRIME: state_n = STREAM;
        STREAM:      state_n = STREAM;
        default:     state_n = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_n;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      fetch_pc   <= RESET_PC;
      rsp_pc     <= '0;
      rsp_valid  <= 1'b0;
      hold_insn  <= '0;
      hold_valid <= 1'b0;
      insn       <= NOP_INSN;
      pc         <= '0;
      run_out    <= 1'b0;
    end else if (redirect_en) begin
      fetch_pc   <= target;
      rsp_valid  <= 1'b0;
      hold_valid <= 1'b0;
      run_out    <= 1'b0;
      insn       <= NOP_INSN;
    end else if (!run) begin
      if (state != IDLE) begin
        fetch_pc   <= rewind_pc;
        rsp_valid  <= 1'b0;
        hold_valid <= 1'b0;
        run_out    <= 1'b0;
        insn       <= NOP_INSN;
      end
    end else begin
      unique case (state)
        IDLE, PRIME: begin
          rsp_pc    <= fetch_pc;
          rsp_valid <= 1'b1;
          fetch_pc  <= pc_inc(fetch_pc);
        end
        STREAM: begin
          if (stall) begin
            // imem moves on next cycle; keep the word for rsp_pc.
            if (!hold_valid) begin
              hold_insn  <= imem_rdata;
              hold_valid <= 1'b1;
            end
          end else begin
            insn       <= src;
            pc         <= rsp_pc;
            run_out    <= 1'b1;
            hold_valid <= 1'b0;
            rsp_pc     <= fetch_pc;
            fetch_pc   <= pc_inc(fetch_pc);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: vector table plus corner sequences.
// imem word at byte address a is 32'h1000_0000 + (a >> 2).
module tb_fetch_unit;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        reset;
  logic        run;
  logic        stall;
  logic        redirect_en;
  logic [31:0] redirect_pc;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata;
  logic [31:0] insn;
  logic [31:0] pc;
  logic        run_out;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  fetch_unit dut (
    .clk         (clk),
    .reset       (reset),
    .run         (run),
    .stall       (stall),
    .redirect_en (redirect_en),
    .redirect_pc (redirect_pc),
    .imem_addr   (imem_addr),
    .imem_rdata  (imem_rdata),
    .insn        (insn),
    .pc          (pc),
    .run_out     (run_out)
  );

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return 32'h1000_0000 + (a >> 2);
  endfunction

  always @(posedge clk) imem_rdata <= mem_word(imem_addr);

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  typedef struct {
    logic        run;
    logic        stall;
    logic        ren;
    logic [31:0] rpc;
    logic        ro;
    logic [31:0] epc;
    logic        nop;
  } vec_t;

  function automatic vec_t mk(input logic r, input logic s,
                              input logic re, input logic [31:0] rp,
                              input logic ro, input logic [31:0] ep,
                              input logic np);
    vec_t v;
    v.run = r; v.stall = s; v.ren = re; v.rpc = rp;
    v.ro = ro; v.epc = ep; v.nop = np;
    return v;
  endfunction

  vec_t tbl[$];

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic run_drop(input logic st, input logic [31:0] first);
    int n;
    run = 1; stall = 0; redirect_en = 1; redirect_pc = 32'h40;
    tick();
    redirect_en = 0;
    tick();
    tick();
    chk("drop_setup_ro", 32'(run_out), 32'd1);
    chk("drop_setup_pc", pc, 32'h40);
    run = 0; stall = st;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk($sformatf("drop%0d_idle%0d_ro", st, i), 32'(run_out), 32'd0);
    end
    run = 1; stall = 0;
    n = 0;
    for (int i = 0; i < 8 && !run_out; i++) begin
      tick();
      n++;
    end
    chk($sformatf("drop%0d_lat", st), n, 2);
    chk($sformatf("drop%0d_pc", st), pc, first);
    chk($sformatf("drop%0d_insn", st), insn, mem_word(first));
    tick();
    chk($sformatf("drop%0d_next", st), pc, first + 32'd4);
  endtask

  initial begin
    reset = 1; run = 0; stall = 0;
    redirect_en = 0; redirect_pc = '0;

    // basic stream from reset
    tbl.push_back(mk(1,0,0,0,           0,0,1));
    tbl.push_back(mk(1,0,0,0,           1,32'h00,0));
    tbl.push_back(mk(1,0,0,0,           1,32'h04,0));
    tbl.push_back(mk(1,0,0,0,           1,32'h08,0));
    // three-cycle stall at pc=8
    tbl.push_back(mk(1,1,0,0,           1,32'h08,0));
    tbl.push_back(mk(1,1,0,0,           1,32'h08,0));
    tbl.push_back(mk(1,1,0,0,           1,32'h08,0));
    tbl.push_back(mk(1,0,0,0,           1,32'h0C,0));
    tbl.push_back(mk(1,0,0,0,           1,32'h10,0));
    tbl.push_back(mk(1,0,0,0,           1,32'h14,0));
    tbl.push_back(mk(1,0,0,0,           1,32'h18,0));
    tbl.push_back(mk(1,0,0,0,           1,32'h1C,0));
    tbl.push_back(mk(1,0,0,0,           1,32'h20,0));
    // redirect to 0x103 at pc=0x20
    tbl.push_back(mk(1,0,1,32'h103,     0,0,1));
    tbl.push_back(mk(1,0,0,0,           0,0,1));
    tbl.push_back(mk(1,0,0,0,           1,32'h100,0));
    tbl.push_back(mk(1,0,0,0,           1,32'h104,0));
    // redirect while the skid buffer is full
    tbl.push_back(mk(1,1,0,0,           1,32'h104,0));
    tbl.push_back(mk(1,1,0,0,           1,32'h104,0));
    tbl.push_back(mk(1,1,1,32'h200,     0,0,1));
    tbl.push_back(mk(1,0,0,0,           0,0,1));
    tbl.push_back(mk(1,0,0,0,           1,32'h200,0));
    tbl.push_back(mk(1,0,0,0,           1,32'h204,0));
    // pc wrap at top of address space
    tbl.push_back(mk(1,0,1,32'hFFFF_FFFE,0,0,1));
    tbl.push_back(mk(1,0,0,0,           0,0,1));
    tbl.push_back(mk(1,0,0,0,           1,32'hFFFF_FFFC,0));
    tbl.push_back(mk(1,0,0,0,           1,32'h0,0));
    tbl.push_back(mk(1,0,0,0,           1,32'h4,0));
    // redirect with run low lands in idle
    tbl.push_back(mk(0,0,1,32'h300,     0,0,1));
    tbl.push_back(mk(0,0,0,0,           0,0,1));
    tbl.push_back(mk(1,0,0,0,           0,0,1));
    tbl.push_back(mk(1,0,0,0,           1,32'h300,0));
    tbl.push_back(mk(1,0,0,0,           1,32'h304,0));

    tick();
    tick();
    chk("rst_ro",   32'(run_out), 32'd0);
    chk("rst_insn", insn, NOP);
    chk("rst_pc",   pc, 32'd0);
    chk("rst_addr", imem_addr, 32'd0);
    reset = 0;

    foreach (tbl[i]) begin
      run = tbl[i].run;
      stall = tbl[i].stall;
      redirect_en = tbl[i].ren;
      redirect_pc = tbl[i].rpc;
      tick();
      chk($sformatf("v%0d_ro", i), 32'(run_out), 32'(tbl[i].ro));
      if (tbl[i].ro) begin
        chk($sformatf("v%0d_pc", i), pc, tbl[i].epc);
        chk($sformatf("v%0d_insn", i), insn, mem_word(tbl[i].epc));
      end else if (tbl[i].nop) begin
        chk($sformatf("v%0d_nop", i), insn, NOP);
      end
    end
    redirect_en = 0;

    run_drop(1'b1, 32'h40);
    run_drop(1'b0, 32'h44);

    // mid-stream reset
    run = 1; stall = 0;
    reset = 1;
    tick();
    chk("mrst_ro",   32'(run_out), 32'd0);
    chk("mrst_insn", insn, NOP);
    chk("mrst_addr", imem_addr, 32'd0);
    chk("mrst_pc",   pc, 32'd0);
    reset = 0;
    tick();
    chk("mrst_e0_ro", 32'(run_out), 32'd0);
    tick();
    chk("mrst_e1_ro", 32'(run_out), 32'd1);
    chk("mrst_e1_pc", pc, 32'd0);
    tick();
    chk("mrst_e2_pc", pc, 32'd4);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
